// File: rtl/stopwatch_pkg.sv
// Shared types for the lap stopwatch: FSM state encoding and the BCD digit type.
// Pure declarations; no timing or flow-control behaviour of its own.
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} sw_state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clears or increments on the clock, wrapping 9->0.
// q is registered (1 cycle); carry is combinational so a whole chain ripples within one cycle.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);
  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (inc)
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc && (q_q == BCD_MAX);
endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch core: tick-prescaled BCD counter, run/pause/clear FSM and lap memory with recall.
// live_bcd lags the qualifying tick by 1 cycle; lap_bcd lags lap_idx by 1 cycle; no backpressure.
module lap_stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int NDIGITS         = 4,
  parameter int LAP_DEPTH       = 8,
  parameter int TICKS_PER_COUNT = 10,
  localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
  localparam int CNT_W = $clog2(LAP_DEPTH + 1),
  localparam int PSC_W = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 ststop,
  input  logic                 lap,
  input  logic                 clear,
  input  logic                 recall,
  output logic                 run,
  output logic [4*NDIGITS-1:0] live_bcd,
  output logic [4*NDIGITS-1:0] lap_bcd,
  output logic [IDX_W-1:0]     lap_idx,
  output logic [CNT_W-1:0]     lap_cnt,
  output logic                 lap_full,
  output logic                 rollover
);
  sw_state_t            state_q;
  logic                 run_q;
  logic [PSC_W-1:0]     psc_q, psc_d;
  logic [CNT_W-1:0]     lap_cnt_q, lap_cnt_d;
  logic [IDX_W-1:0]     lap_idx_q, lap_idx_d;
  logic [4*NDIGITS-1:0] lap_bcd_q, lap_bcd_d;
  logic                 rollover_q, rollover_d;
  logic [4*NDIGITS-1:0] lap_mem [LAP_DEPTH];

  logic                 running, clear_acc, lap_acc, count_en, full;
  logic [NDIGITS:0]     inc_chain;
  bcd_t [NDIGITS-1:0]   dig;

  assign running = (state_q == RUNNING);
  // ststop+clear in IDLE is a plain start, so clear is only honoured without ststop there.
  assign clear_acc = clear && ((state_q == PAUSED) || ((state_q == IDLE) && !ststop));
  assign full      = (lap_cnt_q == CNT_W'(LAP_DEPTH));
  assign lap_acc   = running && lap && !full;
  assign count_en  = running && tick && (psc_q == PSC_W'(TICKS_PER_COUNT - 1));

  assign inc_chain[0] = count_en;
  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_acc),
      .inc   (inc_chain[g]),
      .q     (dig[g]),
      .carry (inc_chain[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ststop) begin
          state_q <= RUNNING;
          run_q   <= 1'b1;
        end
        RUNNING: if (ststop) begin
          state_q <= PAUSED;
          run_q   <= 1'b0;
        end
        PAUSED: if (clear) begin
          state_q <= IDLE;
          run_q   <= 1'b0;
        end else if (ststop) begin
          state_q <= RUNNING;
          run_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    psc_d      = psc_q;
    lap_cnt_d  = lap_cnt_q;
    lap_idx_d  = lap_idx_q;
    rollover_d = rollover_q;
    if (running && tick)
      psc_d = count_en ? '0 : psc_q + PSC_W'(1);
    if (inc_chain[NDIGITS])
      rollover_d = 1'b1;
    if (lap_acc) begin
      lap_cnt_d = lap_cnt_q + CNT_W'(1);
      lap_idx_d = IDX_W'(lap_cnt_q);
    end else if (recall && (lap_cnt_q != '0)) begin
      lap_idx_d = (CNT_W'(lap_idx_q) + CNT_W'(1) == lap_cnt_q) ? '0 : lap_idx_q + IDX_W'(1);
    end
    if (clear_acc) begin
      psc_d      = '0;
      lap_cnt_d  = '0;
      lap_idx_d  = '0;
      rollover_d = 1'b0;
    end
    lap_bcd_d = (lap_cnt_q == '0) ? '0 : lap_mem[lap_idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q      <= '0;
      lap_cnt_q  <= '0;
      lap_idx_q  <= '0;
      lap_bcd_q  <= '0;
      rollover_q <= 1'b0;
    end else begin
      psc_q      <= psc_d;
      lap_cnt_q  <= lap_cnt_d;
      lap_idx_q  <= lap_idx_d;
      lap_bcd_q  <= lap_bcd_d;
      rollover_q <= rollover_d;
    end
  end

  // Storage carries no reset: entries are only visible once lap_cnt covers them.
  always_ff @(posedge clk) begin
    if (!reset && lap_acc)
      lap_mem[IDX_W'(lap_cnt_q)] <= dig;
  end

  assign run      = run_q;
  assign live_bcd = dig;
  assign lap_bcd  = lap_bcd_q;
  assign lap_idx  = lap_idx_q;
  assign lap_cnt  = lap_cnt_q;
  assign lap_full = full;
  assign rollover = rollover_q;
endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Scoreboard bench: expectations are queued as stimulus is applied, then popped against DUT outputs.
// A second instance with a 1-tick prescale reaches the 9999 wrap in a practical number of cycles.
module tb_lap_stopwatch_core;
  logic        clk = 1'b0;
  logic        reset, tick, ststop, lap, clear, recall;
  logic        run, lap_full, rollover;
  logic [15:0] live_bcd, lap_bcd;
  logic [2:0]  lap_idx;
  logic [3:0]  lap_cnt;
  logic        f_run, f_lap_full, f_rollover;
  logic [15:0] f_live_bcd, f_lap_bcd;
  logic [2:0]  f_lap_idx;
  logic [3:0]  f_lap_cnt;

  int n_chk = 0;
  int n_pass = 0;
  string       tag_q[$];
  int          sel_q[$];
  logic [31:0] val_q[$];

  localparam int S_RUN = 0, S_LIVE = 1, S_LBCD = 2, S_IDX = 3, S_CNT = 4, S_FULL = 5, S_ROLL = 6;
  localparam int F_LIVE = 7, F_ROLL = 8, F_RUN = 9;

  always #5 clk = ~clk;

  lap_stopwatch_core dut (
    .clk(clk), .reset(reset), .tick(tick), .ststop(ststop), .lap(lap), .clear(clear),
    .recall(recall), .run(run), .live_bcd(live_bcd), .lap_bcd(lap_bcd), .lap_idx(lap_idx),
    .lap_cnt(lap_cnt), .lap_full(lap_full), .rollover(rollover)
  );

  lap_stopwatch_core #(.NDIGITS(4), .LAP_DEPTH(8), .TICKS_PER_COUNT(1)) dut_fast (
    .clk(clk), .reset(reset), .tick(tick), .ststop(ststop), .lap(lap), .clear(clear),
    .recall(recall), .run(f_run), .live_bcd(f_live_bcd), .lap_bcd(f_lap_bcd), .lap_idx(f_lap_idx),
    .lap_cnt(f_lap_cnt), .lap_full(f_lap_full), .rollover(f_rollover)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_RUN:   return {31'd0, run};
      S_LIVE:  return {16'd0, live_bcd};
      S_LBCD:  return {16'd0, lap_bcd};
      S_IDX:   return {29'd0, lap_idx};
      S_CNT:   return {28'd0, lap_cnt};
      S_FULL:  return {31'd0, lap_full};
      S_ROLL:  return {31'd0, rollover};
      F_LIVE:  return {16'd0, f_live_bcd};
      F_ROLL:  return {31'd0, f_rollover};
      F_RUN:   return {31'd0, f_run};
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    val_q.push_back(val);
  endtask

  task automatic score();
    while (sel_q.size() > 0)
      chk(tag_q.pop_front(), sample(sel_q.pop_front()), val_q.pop_front());
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ss, input logic lp, input logic cl, input logic rc);
    ststop = ss; lap = lp; clear = cl; recall = rc;
    cyc();
    ststop = 1'b0; lap = 1'b0; clear = 1'b0; recall = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic expect_reset_vals(input string pfx);
    expect_val({pfx, "_run"}, S_RUN, 0);
    expect_val({pfx, "_live"}, S_LIVE, 0);
    expect_val({pfx, "_lapbcd"}, S_LBCD, 0);
    expect_val({pfx, "_idx"}, S_IDX, 0);
    expect_val({pfx, "_cnt"}, S_CNT, 0);
    expect_val({pfx, "_full"}, S_FULL, 0);
    expect_val({pfx, "_roll"}, S_ROLL, 0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; ststop = 1'b0; lap = 1'b0; clear = 1'b0; recall = 1'b0;
    cyc(); cyc();
    expect_reset_vals("rst"); score();
    reset = 1'b0;

    pulse(1, 0, 0, 0);
    ticks(250);
    expect_val("run_after_start", S_RUN, 1);
    expect_val("live_250", S_LIVE, 16'h0025); score();
    ticks(9);
    expect_val("psc_zero_hold", S_LIVE, 16'h0025); score();
    ticks(1);
    expect_val("psc_zero_inc", S_LIVE, 16'h0026); score();

    ticks(160);
    expect_val("live_42", S_LIVE, 16'h0042); score();
    pulse(0, 1, 0, 0);
    ticks(30);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    cyc();
    expect_val("two_laps_cnt", S_CNT, 2);
    expect_val("two_laps_idx", S_IDX, 1);
    expect_val("two_laps_bcd", S_LBCD, 16'h0045);
    expect_val("paused_run", S_RUN, 0); score();
    pulse(0, 0, 0, 1); cyc();
    expect_val("recall_wrap", S_LBCD, 16'h0042); score();
    pulse(0, 0, 0, 1); cyc();
    expect_val("recall_next", S_LBCD, 16'h0045); score();
    pulse(0, 1, 0, 0);
    expect_val("lap_paused_ignored", S_CNT, 2); score();

    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    expect_val("clr_running_live", S_LIVE, 16'h0045);
    expect_val("clr_running_cnt", S_CNT, 2);
    expect_val("clr_running_run", S_RUN, 1); score();
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    cyc();
    expect_val("clr_paused_live", S_LIVE, 0);
    expect_val("clr_paused_cnt", S_CNT, 0);
    expect_val("clr_paused_run", S_RUN, 0);
    expect_val("clr_paused_lapbcd", S_LBCD, 0); score();

    do_reset();
    pulse(1, 0, 0, 0);
    ticks(9999);
    expect_val("fast_9999", F_LIVE, 16'h9999);
    expect_val("fast_no_roll_yet", F_ROLL, 0); score();
    ticks(1);
    expect_val("fast_wrap_live", F_LIVE, 16'h0000);
    expect_val("fast_wrap_roll", F_ROLL, 1);
    expect_val("fast_wrap_run", F_RUN, 1);
    expect_val("slow_10000_ticks", S_LIVE, 16'h1000); score();
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    expect_val("fast_clr_roll", F_ROLL, 0);
    expect_val("fast_clr_run", F_RUN, 0);
    expect_val("fast_clr_live", F_LIVE, 0); score();

    do_reset();
    pulse(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      ticks(10);
      pulse(0, 1, 0, 0);
    end
    expect_val("fill_full", S_FULL, 1);
    expect_val("fill_cnt", S_CNT, 8); score();
    ticks(10);
    pulse(0, 1, 0, 0);
    cyc();
    expect_val("ninth_cnt", S_CNT, 8);
    expect_val("ninth_idx", S_IDX, 7);
    expect_val("entry7_kept", S_LBCD, 16'h0008); score();
    pulse(0, 0, 0, 1); cyc();
    expect_val("full_recall_wrap", S_LBCD, 16'h0001); score();

    do_reset();
    pulse(1, 0, 0, 0);
    ticks(1070);
    pulse(1, 1, 0, 0);
    expect_val("sslap_run", S_RUN, 0);
    expect_val("sslap_cnt", S_CNT, 1);
    expect_val("sslap_idx", S_IDX, 0); score();
    cyc();
    expect_val("sslap_bcd", S_LBCD, 16'h0107); score();

    do_reset();
    pulse(1, 0, 0, 0);
    ticks(7);
    pulse(1, 0, 0, 0);
    ticks(100);
    expect_val("paused_hold", S_LIVE, 0); score();
    pulse(1, 0, 0, 0);
    ticks(2);
    expect_val("resume_partial", S_LIVE, 16'h0000); score();
    ticks(1);
    expect_val("resume_one_inc", S_LIVE, 16'h0001); score();

    ticks(25);
    pulse(0, 1, 0, 0);
    reset = 1'b1; tick = 1'b1; lap = 1'b1;
    cyc();
    reset = 1'b0; tick = 1'b0; lap = 1'b0;
    expect_reset_vals("midrst"); score();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lap_stopwatch_core.md
Name: lap_stopwatch_core

Overview:
- Parametrised stopwatch datapath and control: N-digit BCD elapsed-time counter, run/pause/clear state machine and a multi-entry lap memory with recall scrolling.
- Sits between the debounce/single-pulse front end and the seven-segment controller.
- Runs on the system clock and advances on a 1 kHz tick enable instead of a derived clock.
- Successor to the single-register lap design: configurable digit count, lap depth and prescale.

Parameters:
- NDIGITS, 4, number of BCD digits in the live and lap values (digit 0 = least significant).
- LAP_DEPTH, 8, number of lap entries stored (>=1).
- TICKS_PER_COUNT, 10, tick pulses per least-significant-digit increment (10 gives 0.01 s resolution from 1 kHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle time-base enable strobe.
- ststop  in  1  single-cycle start/stop pulse.
- lap  in  1  single-cycle lap-capture pulse.
- clear  in  1  single-cycle clear pulse.
- recall  in  1  single-cycle pulse that steps the displayed lap entry.
- run  out  1  high in RUNNING.
- live_bcd  out  4*NDIGITS  current elapsed time, packed BCD.
- lap_bcd  out  4*NDIGITS  lap entry selected by lap_idx, packed BCD.
- lap_idx  out  $clog2(LAP_DEPTH) (min 1)  index of displayed entry.
- lap_cnt  out  $clog2(LAP_DEPTH+1)  number of stored entries.
- lap_full  out  1  lap_cnt == LAP_DEPTH.
- rollover  out  1  sticky: counter wrapped from all-9s.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - State = IDLE.
  - Outputs: run=0, live_bcd=0, lap_bcd=0, lap_idx=0, lap_cnt=0, lap_full=0, rollover=0.
  - Prescaler = 0. Lap memory contents are don't-care.
- States and transitions:
  - IDLE --ststop--> RUNNING.
  - RUNNING --ststop--> PAUSED.
  - PAUSED --ststop--> RUNNING.
  - PAUSED --clear--> IDLE.
  - IDLE --clear--> IDLE. Clear in IDLE still flushes the laps and the rollover flag.
  - clear is ignored in RUNNING.
- Clear (when accepted):
  - live_bcd=0, prescaler=0, lap_cnt=0, lap_idx=0, rollover=0.
  - lap_bcd=0 on the next cycle.
- Counting happens only in RUNNING.
  - Each tick increments the prescaler.
  - On a tick with prescaler==TICKS_PER_COUNT-1, the prescaler goes to 0 and the BCD chain increments.
  - Each digit wraps 9->0 and carries into the next digit.
  - live_bcd is valid the cycle after the qualifying tick.
- PAUSED holds both the prescaler and the digits, so resuming loses no partial count.
- Wrap: all digits 9 plus an increment gives all 0 with rollover=1, held until clear or reset.
- Lap capture:
  - Accepted only in RUNNING with lap_full=0.
  - Writes the current registered live_bcd (the pre-increment value if tick coincides) into entry lap_cnt.
  - lap_cnt increments, lap_idx = the new entry.
  - lap_bcd shows it one cycle later.
  - Lap in IDLE, in PAUSED, or when full: ignored, no state change.
- Recall:
  - When lap_cnt>0: lap_idx = (lap_idx+1) mod lap_cnt.
  - When lap_cnt==0: ignored.
  - Allowed in any state.
  - lap_bcd is registered and follows lap_idx with 1-cycle latency.
  - lap_bcd=0 whenever lap_cnt==0.
- Simultaneous events in the same cycle:
  - ststop+lap in RUNNING: the capture is taken, then the state goes to PAUSED.
  - lap+recall: lap wins and recall is dropped.
  - clear+ststop in PAUSED: clear wins and the state goes to IDLE.
  - ststop+clear in IDLE: ststop wins and the state goes to RUNNING. Clear is a no-op there, since IDLE already holds zero.
- Reset mid-count or mid-capture: all side effects are abandoned and the block returns to the reset values above.

Decomposition:
- stopwatch_pkg holds:
  - sw_state_t enum {IDLE, RUNNING, PAUSED}.
  - bcd_t typedef (logic [3:0]).
  - BCD_MAX constant = 4'd9.
- Sub-module bcd_digit:
  - Ports: clk, reset, clr, inc, q[3:0], carry.
  - carry is combinational: inc && q==9.
  - Chained NDIGITS times through a generate loop.
- Lap memory is a register array local to the core. No RAM macro.

Test Plan:
- Reset, ststop, then 250 ticks (TICKS_PER_COUNT=10) -> run=1, live_bcd=16'h0025, prescaler=0.
- Running at 0042: lap; 30 ticks; lap; ststop -> lap_cnt=2, lap_idx=1, lap_bcd=0045. Then recall, recall -> lap_bcd shows 0042, then 0045.
- Preload to 9999 via ticks, then 10 more ticks -> live_bcd=0000, rollover=1, run still 1. Then ststop, clear -> rollover=0, state IDLE.
- Fill LAP_DEPTH=8 laps -> lap_full=1. A 9th lap -> lap_cnt stays 8 and entry 7 is unchanged.
- ststop+lap in the same cycle at 0107 -> new entry 0107, run=0.
- Clear while RUNNING -> no effect.
- Pause at prescaler=7, wait 100 ticks, resume, 3 ticks -> exactly one increment.
- Reset asserted mid-run -> all outputs return to reset values the next cycle.
